mux_channel_scanner: RTL and testbench
======================================

MUX_CHANNEL_SCANNER -- requirements
Module: mux_channel_scanner

Interface
REQ-001 Parameter DWELL, default 2, settle cycles held on each channel before its sample cycle; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request one scan; honoured only in IDLE.
REQ-005 chan_en  input  8  channel enable mask; bit k enables mux input k; sampled on the accepted start edge only.
REQ-006 sel  output  3  mux select to the downstream 8:1 mux; sel[0]=sel1, sel[1]=sel2, sel[2]=sel3.
REQ-007 mux_out  input  1  8:1 mux output returned to this block.
REQ-008 frame  output  8  scan result; bit k = sample of channel k; 0 for disabled channels.
REQ-009 frame_valid  output  1  frame holds a complete scan.
REQ-010 frame_ready  input  1  consumer accepts frame.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 overrun  output  1  sticky flag: a start arrived outside IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, HOLD.
REQ-014 IDLE, start=1, chan_en!=0: latch mask, ch = lowest enabled index, cnt = DWELL, clear frame to 0, go SETTLE.
REQ-015 IDLE, start=1, chan_en==0: frame = 0, go directly to HOLD.
REQ-016 SETTLE with cnt>0: decrement cnt; sel = ch.
REQ-017 SETTLE with cnt==0 (sample cycle): frame[ch] <= mux_out at the edge ending the cycle; then go to the next higher enabled channel with cnt = DWELL, or to HOLD if there is none.
REQ-018 Each enabled channel SHALL occupy exactly DWELL+1 cycles; disabled channels SHALL be skipped with zero cycles.
REQ-019 For N enabled channels, frame_valid SHALL be high starting N*(DWELL+1) edges after the start-capturing edge (N=0: 1 edge).
REQ-020 HOLD: frame_valid=1, frame stable; on an edge with frame_ready=1, go to IDLE and drop frame_valid.
REQ-021 frame_ready outside HOLD SHALL be ignored.
REQ-022 frame SHALL retain its last value in IDLE until the next accepted start.
REQ-023 sel SHALL equal ch in SETTLE and SHALL be 0 in IDLE and HOLD.
REQ-024 start while busy (including the HOLD transfer edge) SHALL be ignored for scanning and SHALL set overrun; only reset clears overrun.
REQ-025 chan_en changes after the accepted start SHALL have no effect on the current scan.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, sel=0, frame=0, frame_valid=0, busy=0, overrun=0, cnt=0, latched mask=0.
REQ-027 Reset mid-scan or in HOLD SHALL abandon the scan with no frame_valid pulse; start SHALL be ignored while rst_n=0.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, SETTLE, HOLD), the channel count constant 8, and the cnt width constant 4.
REQ-029 One sub-module, mux_next_chan, SHALL be combinational: given the 8-bit mask and the current index, it returns the next higher enabled index and a none-left flag; it also serves the lowest-enabled search by using a start-below-0 mode.
REQ-030 The block SHALL contain no multiplexing of data other than driving sel.

Verification (bench instantiates the existing 8:1 mux with sel wired per REQ-006)
REQ-031 Inputs i7..i0 = 8'b1010_0110, chan_en=8'hFF, DWELL=2, start pulse -> frame_valid after 24 edges, frame=8'hA6, sel steps 0..7 holding 3 cycles each.
REQ-032 chan_en=8'b1000_0001, inputs all 1 -> sel visits only 0 and 7, frame=8'h81, frame_valid after 6 edges.
REQ-033 chan_en=8'h00, start -> frame=8'h00, frame_valid after 1 edge, sel stays 0.
REQ-034 frame_ready held 0 for 10 cycles in HOLD while pulsing start -> frame stable, frame_valid stays 1, overrun=1; then frame_ready=1 -> IDLE next edge, overrun still 1.
REQ-035 rst_n=0 for one edge mid-scan (chan_en=8'hFF, after edge 10) -> all outputs 0 next cycle, no frame_valid; a subsequent fresh start completes normally.
REQ-036 DWELL=0, chan_en=8'hFF -> sel changes every cycle, frame_valid after 8 edges; changing chan_en mid-scan leaves frame unaffected.

Source files
------------

// File: rtl/mux_channel_scanner_pkg.sv
// Shared types and sizing constants for the mux channel scanner.
//   state_t : scanner FSM states
//   NUM_CH  : number of mux inputs scanned
//   CH_W    : width of a channel index
//   CNT_W   : width of the dwell counter
package mux_channel_scanner_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_channel_scanner_next_chan.sv
// mux_next_chan: combinational search for the next enabled channel.
//   mask      : channel enable mask
//   cur       : current channel index
//   from_zero : search from index 0 inclusive (lowest-enabled search)
//   nxt_c     : next enabled index above cur (or lowest when from_zero)
//   none_c    : no enabled index found
module mux_next_chan
    import mux_channel_scanner_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              from_zero,
    output logic [CH_W-1:0]   nxt_c,
    output logic              none_c
);

    // Scan downwards so the last hit is the lowest qualifying index.
    always_comb begin
        nxt_c  = '0;
        none_c = 1'b1;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mask[i] && (from_zero || (CH_W'(i) > cur))) begin
                nxt_c  = CH_W'(i);
                none_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// mux_channel_scanner: steps an external 8:1 mux across the enabled
// channels, holding each for DWELL settle cycles plus one sample cycle,
// and assembles the samples into a frame handed off with valid/ready.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : request a scan (accepted in IDLE only)
//   chan_en      : channel enable mask, captured with start
//   sel          : mux select driven to the external mux
//   mux_out      : external mux output
//   frame        : sampled bits, one per channel
//   frame_valid  : frame complete, waiting for frame_ready
//   frame_ready  : consumer takes the frame
//   busy         : scan or hand-off in progress
//   overrun      : sticky, a start arrived while busy
module mux_channel_scanner
    import mux_channel_scanner_pkg::*;
#(
    parameter int unsigned DWELL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] chan_en,
    output logic [CH_W-1:0]   sel,
    input  logic              mux_out,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy,
    output logic              overrun
);

    state_t            state;
    logic [NUM_CH-1:0] mask_q;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  cnt;

    logic [NUM_CH-1:0] search_mask;
    logic [CH_W-1:0]   nxt_c;
    logic              none_c;
    logic              in_idle_c;

    // In IDLE the search looks at the live mask for the first channel;
    // afterwards it walks the latched mask upwards from ch.
    assign in_idle_c   = (state == IDLE);
    assign search_mask = in_idle_c ? chan_en : mask_q;

    mux_next_chan u_next (
        .mask      (search_mask),
        .cur       (ch),
        .from_zero (in_idle_c),
        .nxt_c     (nxt_c),
        .none_c    (none_c)
    );

    // Scanner FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            cnt         <= '0;
            mask_q      <= '0;
            ch          <= '0;
        end else begin
            if (start && !in_idle_c) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        frame  <= '0;
                        busy   <= 1'b1;
                        mask_q <= chan_en;
                        if (chan_en != '0) begin
                            ch    <= nxt_c;
                            sel   <= nxt_c;
                            cnt   <= CNT_W'(DWELL);
                            state <= SETTLE;
                        end else begin
                            frame_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end

                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Sample cycle: capture, then advance or finish.
                        frame[ch] <= mux_out;
                        if (none_c) begin
                            sel         <= '0;
                            frame_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            ch  <= nxt_c;
                            sel <= nxt_c;
                            cnt <= CNT_W'(DWELL);
                        end
                    end
                end

                HOLD: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Testbench: two scanners (DWELL=2 and DWELL=0) share stimulus, each
// driving its own behavioural 8:1 mux. Expected sel traces, latency and
// frame come from a per-channel schedule built from the enable mask.
module tb_mux_channel_scanner;

    localparam int unsigned DW_A = 2;
    localparam int unsigned DW_B = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       frame_ready;
    logic [7:0] chan_en;
    logic [7:0] ins;

    logic [2:0] sel_a, sel_b;
    logic [7:0] frame_a, frame_b;
    logic       fv_a, fv_b, busy_a, busy_b, ov_a, ov_b;
    logic       mo_a, mo_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Behavioural 8:1 muxes, select bit 0 = sel1 ... bit 2 = sel3.
    assign mo_a = ins[sel_a];
    assign mo_b = ins[sel_b];

    mux_channel_scanner #(.DWELL(DW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .chan_en(chan_en),
        .sel(sel_a), .mux_out(mo_a), .frame(frame_a), .frame_valid(fv_a),
        .frame_ready(frame_ready), .busy(busy_a), .overrun(ov_a)
    );

    mux_channel_scanner #(.DWELL(DW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .chan_en(chan_en),
        .sel(sel_b), .mux_out(mo_b), .frame(frame_b), .frame_valid(fv_b),
        .frame_ready(frame_ready), .busy(busy_b), .overrun(ov_b)
    );

    function automatic logic [2:0] g_sel(int d);
        return (d == 0) ? sel_a : sel_b;
    endfunction
    function automatic logic [7:0] g_frame(int d);
        return (d == 0) ? frame_a : frame_b;
    endfunction
    function automatic logic g_fv(int d);
        return (d == 0) ? fv_a : fv_b;
    endfunction
    function automatic logic g_busy(int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic g_ov(int d);
        return (d == 0) ? ov_a : ov_b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; frame_ready = 1'b0;
        chan_en = 8'hFF; ins = 8'h00;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({g_sel(d), g_frame(d), g_fv(d), g_busy(d), g_ov(d)} !== 14'd0) begin
                fails++;
                $display("FAIL reset dut%0d got sel=%0d frame=%h fv=%b busy=%b ov=%b required all 0",
                         d, g_sel(d), g_frame(d), g_fv(d), g_busy(d), g_ov(d));
            end
        end
        start = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    // One scan on both DUTs, checked every cycle against the schedule.
    task automatic do_scan(input string name, input logic [7:0] mask, input logic [7:0] ins_v,
                           input bit mid_change, input bit release_it, output logic [7:0] exp_frame);
        int seq_a[$];
        int seq_b[$];
        int lat [2];
        int maxl;
        int exp_sel;
        exp_frame = mask & ins_v;
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) begin
                for (int r = 0; r <= int'(DW_A); r++) seq_a.push_back(k);
                for (int r = 0; r <= int'(DW_B); r++) seq_b.push_back(k);
            end
        end
        lat[0] = seq_a.size();
        lat[1] = seq_b.size();
        maxl = (lat[0] > lat[1]) ? lat[0] : lat[1];

        chan_en = mask; ins = ins_v; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= maxl; c++) begin
            if (c > 0) tick();
            for (int d = 0; d < 2; d++) begin
                if (c < lat[d]) begin
                    exp_sel = (d == 0) ? seq_a[c] : seq_b[c];
                    tests++;
                    if (g_sel(d) !== 3'(exp_sel) || g_fv(d) !== 1'b0 || g_busy(d) !== 1'b1) begin
                        fails++;
                        $display("FAIL %s scan dut%0d cyc%0d got sel=%0d fv=%b busy=%b required sel=%0d fv=0 busy=1",
                                 name, d, c, g_sel(d), g_fv(d), g_busy(d), exp_sel);
                    end
                end else begin
                    tests++;
                    if (g_sel(d) !== 3'd0 || g_fv(d) !== 1'b1 || g_frame(d) !== exp_frame) begin
                        fails++;
                        $display("FAIL %s hold dut%0d cyc%0d got sel=%0d fv=%b frame=%h required sel=0 fv=1 frame=%h",
                                 name, d, c, g_sel(d), g_fv(d), g_frame(d), exp_frame);
                    end
                end
            end
            if (mid_change && c == 1) chan_en = ~mask;
        end

        if (release_it) begin
            frame_ready = 1'b1;
            tick();
            frame_ready = 1'b0;
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (g_fv(d) !== 1'b0 || g_busy(d) !== 1'b0 || g_frame(d) !== exp_frame || g_sel(d) !== 3'd0) begin
                    fails++;
                    $display("FAIL %s release dut%0d got fv=%b busy=%b frame=%h sel=%0d required fv=0 busy=0 frame=%h sel=0",
                             name, d, g_fv(d), g_busy(d), g_frame(d), g_sel(d), exp_frame);
                end
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] f;
        do_scan("all_on", 8'hFF, 8'b1010_0110, 1'b0, 1'b1, f);
        do_scan("ends", 8'b1000_0001, 8'hFF, 1'b0, 1'b1, f);
        do_scan("none", 8'h00, 8'hFF, 1'b0, 1'b1, f);
        do_scan("mid_chg", 8'hFF, 8'h5C, 1'b1, 1'b1, f);
    endtask

    task automatic test_random();
        logic [7:0] f;
        for (int i = 0; i < 10; i++) begin
            do_scan("rand", 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), 1'b1, f);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] f;
        do_scan("ovr", 8'b0110_1001, 8'($urandom), 1'b0, 1'b0, f);
        frame_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (g_fv(d) !== 1'b1 || g_frame(d) !== f || g_ov(d) !== 1'b1 || g_busy(d) !== 1'b1) begin
                    fails++;
                    $display("FAIL overrun_hold dut%0d cyc%0d got fv=%b frame=%h ov=%b busy=%b required fv=1 frame=%h ov=1 busy=1",
                             d, i, g_fv(d), g_frame(d), g_ov(d), g_busy(d), f);
                end
            end
        end
        // Start coincident with the transfer edge must not launch a scan.
        start = 1'b1; frame_ready = 1'b1;
        tick();
        start = 1'b0; frame_ready = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (g_fv(d) !== 1'b0 || g_busy(d) !== 1'b0 || g_ov(d) !== 1'b1 || g_frame(d) !== f) begin
                fails++;
                $display("FAIL overrun_release dut%0d got fv=%b busy=%b ov=%b frame=%h required fv=0 busy=0 ov=1 frame=%h",
                         d, g_fv(d), g_busy(d), g_ov(d), g_frame(d), f);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] f;
        chan_en = 8'hFF; ins = 8'($urandom); start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0; start = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({g_sel(d), g_frame(d), g_fv(d), g_busy(d), g_ov(d)} !== 14'd0) begin
                fails++;
                $display("FAIL mid_reset dut%0d got sel=%0d frame=%h fv=%b busy=%b ov=%b required all 0",
                         d, g_sel(d), g_frame(d), g_fv(d), g_busy(d), g_ov(d));
            end
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (g_fv(d) !== 1'b0 || g_busy(d) !== 1'b0) begin
                    fails++;
                    $display("FAIL post_reset_idle dut%0d cyc%0d got fv=%b busy=%b required fv=0 busy=0",
                             d, c, g_fv(d), g_busy(d));
                end
            end
        end
        do_scan("after_rst", 8'hFF, 8'($urandom), 1'b0, 1'b1, f);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_overrun();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
